multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
Multi-cycle successor to the single-cycle MIPS control unit. An FSM sequences each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the same datapath controls as single-cycle pulses. It adds a memory request/ready handshake, instruction/PC write strobes, a parametrised multi-cycle wait for MUL and an illegal-opcode flag. It sits between the instruction register and the shared-memory multi-cycle datapath.

Parameters:
ALU_OP_W, 4, width of opALU. R-type default passes funct[ALU_OP_W-1:0].
MULDIV_LAT, 4, number of EXEC cycles held for MUL (SPECIAL2 011100); legal range 1..15.
ENABLE_MUL, 1, when 0 the MUL opcode is treated as illegal.

Ports:
clk  in  1  clock; all state changes on the rising edge
reset  in  1  synchronous, active-high reset
opcode  in  6  instruction opcode field, sampled in DECODE
funct  in  6  instruction funct field, sampled in DECODE
alu_zero  in  1  ALU zero flag, used by BEQ in EXEC
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory access request (FETCH, MEM)
ir_write  out  1  load the instruction register
pc_write  out  1  update PC with the pc_src selection
pc_src  out  2  00 branch target, 01 jump target, 10 rs, 11 PC+1
reg_dst  out  2  0 rt, 1 rd, 2 $ra
mem_to_reg  out  1  register write data comes from memory
opALU  out  ALU_OP_W  ALU operation: 1 add, 2 sub, 3 and, 4 or, 5 xor
origALU  out  1  0 rt operand, 1 immediate
write_enable_mem  out  1  data memory write strobe
write_enable_reg  out  1  register file write strobe
illegal_op  out  1  one-cycle pulse on an unknown opcode
state_o  out  3  current state: 0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB

Behaviour:
- Reset: state=FETCH, mul counter=0, latched op/funct=0. While reset=1 all outputs are forced to defaults: strobes 0, mem_req 0, pc_src=11, opALU=0, reg_dst=0, state_o=0. FETCH starts on the first cycle after reset deasserts.
- Outputs are combinational from the state and the latched op/funct.
- Strobes (ir_write, pc_write, write_enable_*) are high for exactly one cycle per event.
- FETCH: mem_req=1. Hold until mem_ready=1. In that cycle ir_write=1, pc_write=1, pc_src=11, then go to DECODE.
- DECODE: latch opcode/funct into op_q/funct_q. If the opcode is unknown, pulse illegal_op and go to FETCH. Otherwise go to EXEC.
- EXEC, by op_q:
  - R-type (funct ≠ 001000/001001): opALU=funct_q[ALU_OP_W-1:0], origALU=0, next WB.
  - JR: pc_write=1, pc_src=10, next FETCH.
  - JALR: pc_write=1, pc_src=10, write_enable_reg=1, reg_dst=2, next FETCH.
  - ADDI/ANDI/ORI/XORI: opALU=1/3/4/5, origALU=1, next WB.
  - LW/SW: opALU=1, origALU=1, next MEM.
  - BEQ: opALU=2, origALU=0, pc_src=00, pc_write=alu_zero, next FETCH.
  - J: pc_write=1, pc_src=01, next FETCH.
  - JAL: as J, plus write_enable_reg=1, reg_dst=2.
  - MUL: stay in EXEC for MULDIV_LAT cycles using the counter (cleared on exit), opALU=0, reg_dst=1, then WB.
- MEM: mem_req=1 and hold until mem_ready. SW: write_enable_mem=1 only in the mem_ready cycle, then FETCH. LW: in the mem_ready cycle go to WB.
- WB: write_enable_reg=1 for one cycle, then FETCH.
  - R-type/MUL: reg_dst=1.
  - I-type: reg_dst=0.
  - LW: reg_dst=0, mem_to_reg=1.
  - opALU/origALU are held from EXEC through WB.
- Latency with zero-wait memory:
  - R/I-type: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ/J/JAL/JR/JALR: 3 cycles.
  - MUL: 3+MULDIV_LAT cycles.
  - Each mem_ready wait cycle adds one.
- Boundary conditions:
  - mem_ready outside FETCH/MEM is ignored.
  - Reset asserted mid-instruction aborts it, with no strobe issued in that cycle.
  - opcode/funct changes after DECODE have no effect.
  - MULDIV_LAT=1 behaves like a single EXEC cycle.
  - unreachable state codes go to FETCH.

Test Plan:
- ADD (op 000000, funct 100000), mem_ready tied 1 -> ir_write at cycle 0; opALU=0 (funct[3:0]) at cycle 2; write_enable_reg=1 with reg_dst=1 at cycle 3; FETCH again at cycle 4.
- LW with mem_ready low for 2 cycles in MEM -> mem_req held 3 cycles; WB has mem_to_reg=1, write_enable_reg=1, reg_dst=0; write_enable_mem never 1.
- BEQ with alu_zero=1, then with alu_zero=0 -> pc_write=1 with pc_src=00 in EXEC for the first; pc_write=0 in EXEC for the second; 3 cycles each.
- MUL with MULDIV_LAT=4 -> state_o=2 for 4 consecutive cycles, then WB with write_enable_reg=1; 7 cycles total. With ENABLE_MUL=0 -> illegal_op pulse in DECODE and no write_enable_reg.
- JAL -> EXEC has pc_write=1, pc_src=01, write_enable_reg=1, reg_dst=2. JALR -> same, but pc_src=10.
- Reset asserted during the MEM stage of SW -> write_enable_mem stays 0; state_o=0 and all strobes 0 while reset=1; FETCH resumes the cycle after release.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and drives
// datapath strobes, with a memory ready handshake and a multi-cycle MUL hold.
module multicycle_control_unit #(
   parameter int unsigned ALU_OP_W   = 4,
   parameter int unsigned MULDIV_LAT = 4,
   parameter bit          ENABLE_MUL = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [5:0]          opcode,
   input  logic [5:0]          funct,
   input  logic                alu_zero,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                ir_write,
   output logic                pc_write,
   output logic [1:0]          pc_src,
   output logic [1:0]          reg_dst,
   output logic                mem_to_reg,
   output logic [ALU_OP_W-1:0] opALU,
   output logic                origALU,
   output logic                write_enable_mem,
   output logic                write_enable_reg,
   output logic                illegal_op,
   output logic [2:0]          state_o
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MULDIV_LAT - 1);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_MUL   = 6'b011100;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] FN_JR    = 6'b001000;
   localparam logic [5:0] FN_JALR  = 6'b001001;

   localparam logic [1:0] PC_BR  = 2'b00;
   localparam logic [1:0] PC_JMP = 2'b01;
   localparam logic [1:0] PC_RS  = 2'b10;
   localparam logic [1:0] PC_SEQ = 2'b11;
   localparam logic [1:0] RD_RT  = 2'd0;
   localparam logic [1:0] RD_RD  = 2'd1;
   localparam logic [1:0] RD_RA  = 2'd2;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic [5:0]         r_op;
   logic [5:0]         r_funct;
   logic [CNT_W-1:0]   r_mul_cnt;
   logic [CNT_W-1:0]   w_mul_cnt_next;
   logic [ALU_OP_W-1:0] w_alu_op;
   logic               w_orig;
   logic               w_is_jr;

   function automatic logic is_legal(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_ANDI,
         OP_ORI, OP_XORI, OP_LW, OP_SW: is_legal = 1'b1;
         OP_MUL:                        is_legal = (ENABLE_MUL != 1'b0);
         default:                       is_legal = 1'b0;
      endcase
   endfunction

   // State, latched instruction fields and MUL hold counter
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_FETCH;
         r_op      <= 6'd0;
         r_funct   <= 6'd0;
         r_mul_cnt <= '0;
      end else begin
         r_state   <= w_next_state;
         r_mul_cnt <= w_mul_cnt_next;
         if (r_state == S_DECODE) begin
            r_op    <= opcode;
            r_funct <= funct;
         end
      end
   end

   // ALU controls from the latched instruction; held from EXEC through WB
   always_comb begin
      w_alu_op = '0;
      w_orig   = 1'b0;
      w_is_jr  = (r_op == OP_RTYPE) && ((r_funct == FN_JR) || (r_funct == FN_JALR));
      case (r_op)
         OP_RTYPE: if (!w_is_jr) w_alu_op = ALU_OP_W'(r_funct);
         OP_ADDI: begin w_alu_op = ALU_OP_W'(1); w_orig = 1'b1; end
         OP_ANDI: begin w_alu_op = ALU_OP_W'(3); w_orig = 1'b1; end
         OP_ORI:  begin w_alu_op = ALU_OP_W'(4); w_orig = 1'b1; end
         OP_XORI: begin w_alu_op = ALU_OP_W'(5); w_orig = 1'b1; end
         OP_LW, OP_SW: begin w_alu_op = ALU_OP_W'(1); w_orig = 1'b1; end
         OP_BEQ:  w_alu_op = ALU_OP_W'(2);
         default: w_alu_op = '0;
      endcase
   end

   // Next state and control outputs; everything stays at defaults during reset
   always_comb begin
      w_next_state     = S_FETCH;
      w_mul_cnt_next   = '0;
      mem_req          = 1'b0;
      ir_write         = 1'b0;
      pc_write         = 1'b0;
      pc_src           = PC_SEQ;
      reg_dst          = RD_RT;
      mem_to_reg       = 1'b0;
      opALU            = '0;
      origALU          = 1'b0;
      write_enable_mem = 1'b0;
      write_enable_reg = 1'b0;
      illegal_op       = 1'b0;
      state_o          = 3'd0;
      if (!reset) begin
         state_o = 3'(r_state);
         case (r_state)
            S_FETCH: begin
               mem_req      = 1'b1;
               w_next_state = S_FETCH;
               if (mem_ready) begin
                  ir_write     = 1'b1;
                  pc_write     = 1'b1;
                  w_next_state = S_DECODE;
               end
            end
            S_DECODE: begin
               if (is_legal(opcode)) w_next_state = S_EXEC;
               else                  illegal_op   = 1'b1;
            end
            S_EXEC: begin
               opALU        = w_alu_op;
               origALU      = w_orig;
               w_next_state = S_WB;
               case (r_op)
                  OP_RTYPE: begin
                     if (w_is_jr) begin
                        pc_write     = 1'b1;
                        pc_src       = PC_RS;
                        w_next_state = S_FETCH;
                        if (r_funct == FN_JALR) begin
                           write_enable_reg = 1'b1;
                           reg_dst          = RD_RA;
                        end
                     end
                  end
                  OP_LW, OP_SW: w_next_state = S_MEM;
                  OP_BEQ: begin
                     pc_src       = PC_BR;
                     pc_write     = alu_zero;
                     w_next_state = S_FETCH;
                  end
                  OP_J: begin
                     pc_write     = 1'b1;
                     pc_src       = PC_JMP;
                     w_next_state = S_FETCH;
                  end
                  OP_JAL: begin
                     pc_write         = 1'b1;
                     pc_src           = PC_JMP;
                     write_enable_reg = 1'b1;
                     reg_dst          = RD_RA;
                     w_next_state     = S_FETCH;
                  end
                  OP_MUL: begin
                     reg_dst = RD_RD;
                     if (r_mul_cnt >= MUL_LAST) begin
                        w_next_state = S_WB;
                     end else begin
                        w_next_state   = S_EXEC;
                        w_mul_cnt_next = r_mul_cnt + CNT_W'(1);
                     end
                  end
                  default: w_next_state = S_WB;
               endcase
            end
            S_MEM: begin
               mem_req      = 1'b1;
               opALU        = w_alu_op;
               origALU      = w_orig;
               w_next_state = S_MEM;
               if (mem_ready) begin
                  if (r_op == OP_SW) begin
                     write_enable_mem = 1'b1;
                     w_next_state     = S_FETCH;
                  end else begin
                     w_next_state = S_WB;
                  end
               end
            end
            S_WB: begin
               opALU            = w_alu_op;
               origALU          = w_orig;
               write_enable_reg = 1'b1;
               w_next_state     = S_FETCH;
               case (r_op)
                  OP_RTYPE, OP_MUL: reg_dst    = RD_RD;
                  OP_LW:            mem_to_reg = 1'b1;
                  default:          reg_dst    = RD_RT;
               endcase
            end
            default: w_next_state = S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle vector table on the default
// build, plus short sequences on ENABLE_MUL=0 and MULDIV_LAT=1 builds.
module tb_multicycle_control_unit;

   typedef struct packed {
      logic [2:0] st;
      logic       req;
      logic       irw;
      logic       pcw;
      logic [1:0] pcs;
      logic [1:0] rd;
      logic       m2r;
      logic [3:0] alu;
      logic       orig;
      logic       wem;
      logic       wer;
      logic       ill;
   } out_t;

   typedef struct packed {
      logic       rst;
      logic [5:0] op;
      logic [5:0] fn;
      logic       z;
      logic       rdy;
      out_t       exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] opcode = 6'd0;
   logic [5:0] funct = 6'd0;
   logic       alu_zero = 1'b0;
   logic       mem_ready = 1'b1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   logic [2:0] st, n_st, l_st;
   logic       req, n_req, l_req, irw, n_irw, l_irw, pcw, n_pcw, l_pcw;
   logic [1:0] pcs, n_pcs, l_pcs, rd, n_rd, l_rd;
   logic       m2r, n_m2r, l_m2r, orig, n_orig, l_orig;
   logic [3:0] alu, n_alu, l_alu;
   logic       wem, n_wem, l_wem, wer, n_wer, l_wer, ill, n_ill, l_ill;
   out_t       a_main;

   assign a_main = {st, req, irw, pcw, pcs, rd, m2r, alu, orig, wem, wer, ill};

   multicycle_control_unit u_dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
      .mem_ready(mem_ready), .mem_req(req), .ir_write(irw), .pc_write(pcw), .pc_src(pcs),
      .reg_dst(rd), .mem_to_reg(m2r), .opALU(alu), .origALU(orig),
      .write_enable_mem(wem), .write_enable_reg(wer), .illegal_op(ill), .state_o(st));

   multicycle_control_unit #(.ENABLE_MUL(1'b0)) u_nomul (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
      .mem_ready(mem_ready), .mem_req(n_req), .ir_write(n_irw), .pc_write(n_pcw), .pc_src(n_pcs),
      .reg_dst(n_rd), .mem_to_reg(n_m2r), .opALU(n_alu), .origALU(n_orig),
      .write_enable_mem(n_wem), .write_enable_reg(n_wer), .illegal_op(n_ill), .state_o(n_st));

   multicycle_control_unit #(.MULDIV_LAT(1)) u_lat1 (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
      .mem_ready(mem_ready), .mem_req(l_req), .ir_write(l_irw), .pc_write(l_pcw), .pc_src(l_pcs),
      .reg_dst(l_rd), .mem_to_reg(l_m2r), .opALU(l_alu), .origALU(l_orig),
      .write_enable_mem(l_wem), .write_enable_reg(l_wer), .illegal_op(l_ill), .state_o(l_st));

   function automatic out_t o(int s, int rq, int iw, int pw, int ps, int r, int mr,
                              int a, int og, int wm, int wr, int il);
      out_t x;
      x.st = 3'(s);   x.req = 1'(rq); x.irw = 1'(iw); x.pcw = 1'(pw);
      x.pcs = 2'(ps); x.rd = 2'(r);   x.m2r = 1'(mr); x.alu = 4'(a);
      x.orig = 1'(og); x.wem = 1'(wm); x.wer = 1'(wr); x.ill = 1'(il);
      return x;
   endfunction

   function automatic vec_t mk(int r, int op, int fn, int z, int rdy, out_t e);
      vec_t v;
      v.rst = 1'(r); v.op = 6'(op); v.fn = 6'(fn); v.z = 1'(z); v.rdy = 1'(rdy); v.exp = e;
      return v;
   endfunction

   task automatic drive(input logic r, input logic [5:0] op_i, input logic [5:0] fn_i,
                        input logic z, input logic rdy);
      @(negedge clk);
      reset = r; opcode = op_i; funct = fn_i; alu_zero = z; mem_ready = rdy;
      #1;
   endtask

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[%0d] got %h want %h", name, idx, act, exp);
      end
   endtask

   vec_t vq[$];
   out_t OF, OFW, OD, ORST;

   initial begin
      OF   = o(0,1,1,1,3,0,0,0,0,0,0,0);
      OFW  = o(0,1,0,0,3,0,0,0,0,0,0,0);
      OD   = o(1,0,0,0,3,0,0,0,0,0,0,0);
      ORST = o(0,0,0,0,3,0,0,0,0,0,0,0);

      vq.push_back(mk(1,'h00,'h00,0,1,ORST));
      vq.push_back(mk(1,'h00,'h00,0,1,ORST));
      // ADD; mem_ready low in DECODE and opcode/funct changed in EXEC/WB
      vq.push_back(mk(0,'h00,'h20,0,1,OF));
      vq.push_back(mk(0,'h00,'h20,0,0,OD));
      vq.push_back(mk(0,'h23,'h08,0,1,o(2,0,0,0,3,0,0,0,0,0,0,0)));
      vq.push_back(mk(0,'h23,'h08,0,0,o(4,0,0,0,3,1,0,0,0,0,1,0)));
      // XOR
      vq.push_back(mk(0,'h00,'h26,0,1,OF));
      vq.push_back(mk(0,'h00,'h26,0,1,OD));
      vq.push_back(mk(0,'h00,'h26,0,1,o(2,0,0,0,3,0,0,6,0,0,0,0)));
      vq.push_back(mk(0,'h00,'h26,0,1,o(4,0,0,0,3,1,0,6,0,0,1,0)));
      // LW with two wait cycles in MEM
      vq.push_back(mk(0,'h23,'h00,0,1,OF));
      vq.push_back(mk(0,'h23,'h00,0,1,OD));
      vq.push_back(mk(0,'h23,'h00,0,1,o(2,0,0,0,3,0,0,1,1,0,0,0)));
      vq.push_back(mk(0,'h23,'h00,0,0,o(3,1,0,0,3,0,0,1,1,0,0,0)));
      vq.push_back(mk(0,'h23,'h00,0,0,o(3,1,0,0,3,0,0,1,1,0,0,0)));
      vq.push_back(mk(0,'h23,'h00,0,1,o(3,1,0,0,3,0,0,1,1,0,0,0)));
      vq.push_back(mk(0,'h23,'h00,0,1,o(4,0,0,0,3,0,1,1,1,0,1,0)));
      // SW with a FETCH wait
      vq.push_back(mk(0,'h2B,'h00,0,0,OFW));
      vq.push_back(mk(0,'h2B,'h00,0,1,OF));
      vq.push_back(mk(0,'h2B,'h00,0,1,OD));
      vq.push_back(mk(0,'h2B,'h00,0,1,o(2,0,0,0,3,0,0,1,1,0,0,0)));
      vq.push_back(mk(0,'h2B,'h00,0,1,o(3,1,0,0,3,0,0,1,1,1,0,0)));
      // BEQ taken, then not taken
      vq.push_back(mk(0,'h04,'h00,1,1,OF));
      vq.push_back(mk(0,'h04,'h00,1,1,OD));
      vq.push_back(mk(0,'h04,'h00,1,1,o(2,0,0,1,0,0,0,2,0,0,0,0)));
      vq.push_back(mk(0,'h04,'h00,0,1,OF));
      vq.push_back(mk(0,'h04,'h00,0,1,OD));
      vq.push_back(mk(0,'h04,'h00,0,1,o(2,0,0,0,0,0,0,2,0,0,0,0)));
      // ADDI, ORI
      vq.push_back(mk(0,'h08,'h00,0,1,OF));
      vq.push_back(mk(0,'h08,'h00,0,1,OD));
      vq.push_back(mk(0,'h08,'h00,0,1,o(2,0,0,0,3,0,0,1,1,0,0,0)));
      vq.push_back(mk(0,'h08,'h00,0,1,o(4,0,0,0,3,0,0,1,1,0,1,0)));
      vq.push_back(mk(0,'h0D,'h00,0,1,OF));
      vq.push_back(mk(0,'h0D,'h00,0,1,OD));
      vq.push_back(mk(0,'h0D,'h00,0,1,o(2,0,0,0,3,0,0,4,1,0,0,0)));
      vq.push_back(mk(0,'h0D,'h00,0,1,o(4,0,0,0,3,0,0,4,1,0,1,0)));
      // J, JAL, JR, JALR
      vq.push_back(mk(0,'h02,'h00,0,1,OF));
      vq.push_back(mk(0,'h02,'h00,0,1,OD));
      vq.push_back(mk(0,'h02,'h00,0,1,o(2,0,0,1,1,0,0,0,0,0,0,0)));
      vq.push_back(mk(0,'h03,'h00,0,1,OF));
      vq.push_back(mk(0,'h03,'h00,0,1,OD));
      vq.push_back(mk(0,'h03,'h00,0,1,o(2,0,0,1,1,2,0,0,0,0,1,0)));
      vq.push_back(mk(0,'h00,'h08,0,1,OF));
      vq.push_back(mk(0,'h00,'h08,0,1,OD));
      vq.push_back(mk(0,'h00,'h08,0,1,o(2,0,0,1,2,0,0,0,0,0,0,0)));
      vq.push_back(mk(0,'h00,'h09,0,1,OF));
      vq.push_back(mk(0,'h00,'h09,0,1,OD));
      vq.push_back(mk(0,'h00,'h09,0,1,o(2,0,0,1,2,2,0,0,0,0,1,0)));
      // MUL, 4-cycle EXEC hold
      vq.push_back(mk(0,'h1C,'h02,0,1,OF));
      vq.push_back(mk(0,'h1C,'h02,0,1,OD));
      for (int k = 0; k < 4; k++)
         vq.push_back(mk(0,'h1C,'h02,0,1,o(2,0,0,0,3,1,0,0,0,0,0,0)));
      vq.push_back(mk(0,'h1C,'h02,0,1,o(4,0,0,0,3,1,0,0,0,0,1,0)));
      // illegal opcode
      vq.push_back(mk(0,'h3F,'h00,0,1,OF));
      vq.push_back(mk(0,'h3F,'h00,0,1,o(1,0,0,0,3,0,0,0,0,0,0,1)));
      // SW aborted by reset in MEM, then AND after release
      vq.push_back(mk(0,'h2B,'h00,0,1,OF));
      vq.push_back(mk(0,'h2B,'h00,0,1,OD));
      vq.push_back(mk(0,'h2B,'h00,0,1,o(2,0,0,0,3,0,0,1,1,0,0,0)));
      vq.push_back(mk(1,'h2B,'h00,0,1,ORST));
      vq.push_back(mk(1,'h2B,'h00,0,1,ORST));
      vq.push_back(mk(0,'h00,'h24,0,1,OF));
      vq.push_back(mk(0,'h00,'h24,0,1,OD));
      vq.push_back(mk(0,'h00,'h24,0,1,o(2,0,0,0,3,0,0,4,0,0,0,0)));
      vq.push_back(mk(0,'h00,'h24,0,1,o(4,0,0,0,3,1,0,4,0,0,1,0)));
      vq.push_back(mk(0,'h00,'h24,0,1,OF));

      foreach (vq[i]) begin
         drive(vq[i].rst, vq[i].op, vq[i].fn, vq[i].z, vq[i].rdy);
         chk("vec", i, 32'(a_main), 32'(vq[i].exp));
      end

      // MUL on the ENABLE_MUL=0 build is illegal; default build accepts it
      drive(1, 6'h1C, 6'h02, 0, 1);
      drive(1, 6'h1C, 6'h02, 0, 1);
      drive(0, 6'h1C, 6'h02, 0, 1);
      chk("nomul_fetch_irw", 0, 32'(n_irw), 32'd1);
      drive(0, 6'h1C, 6'h02, 0, 1);
      chk("nomul_dec_st", 1, 32'(n_st), 32'd1);
      chk("nomul_dec_ill", 1, 32'(n_ill), 32'd1);
      chk("main_dec_ill", 1, 32'(ill), 32'd0);
      drive(0, 6'h1C, 6'h02, 0, 1);
      chk("nomul_back_st", 2, 32'(n_st), 32'd0);
      chk("nomul_ill_pulse", 2, 32'(n_ill), 32'd0);
      chk("nomul_wer", 2, 32'(n_wer), 32'd0);
      chk("main_exec_st", 2, 32'(st), 32'd2);
      drive(0, 6'h1C, 6'h02, 0, 1);
      chk("nomul_wer", 3, 32'(n_wer), 32'd0);

      // MULDIV_LAT=1: single EXEC cycle, WB next
      drive(1, 6'h1C, 6'h02, 0, 1);
      drive(1, 6'h1C, 6'h02, 0, 1);
      drive(0, 6'h1C, 6'h02, 0, 1);
      chk("lat1_st", 0, 32'(l_st), 32'd0);
      drive(0, 6'h1C, 6'h02, 0, 1);
      chk("lat1_st", 1, 32'(l_st), 32'd1);
      drive(0, 6'h1C, 6'h02, 0, 1);
      chk("lat1_st", 2, 32'(l_st), 32'd2);
      chk("lat1_rd", 2, 32'(l_rd), 32'd1);
      chk("lat1_wer", 2, 32'(l_wer), 32'd0);
      drive(0, 6'h1C, 6'h02, 0, 1);
      chk("lat1_st", 3, 32'(l_st), 32'd4);
      chk("lat1_wer", 3, 32'(l_wer), 32'd1);
      chk("main_hold_st", 3, 32'(st), 32'd2);
      drive(0, 6'h1C, 6'h02, 0, 1);
      chk("lat1_st", 4, 32'(l_st), 32'd0);
      chk("lat1_irw", 4, 32'(l_irw), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
